// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multichannel PWM block.
package pwm_pkg;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

  function automatic int unsigned pwm_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-cycle tick every reload_i+1 enabled clocks.
module pwm_prescaler #(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic [PRESCALE_W-1:0] reload_i,
  output logic                  tick_o
);

  logic [PRESCALE_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == reload_i);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (!en_i || tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multichannel.sv
// N-channel PWM with double-buffered duty words, prescaler and edge/center alignment.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [PRESCALE_W-1:0]     prescale_i,
  input  logic [CHANNELS*WIDTH-1:0] duty_i,
  input  logic                      duty_load_i,
  input  logic [CHANNELS-1:0]       inv_i,
  output logic [CHANNELS-1:0]       pwm_o,
  output logic                      period_o
);

  localparam logic [WIDTH-1:0] MAX    = WIDTH'(pwm_max(WIDTH));
  localparam logic [WIDTH-1:0] MAX_M1 = MAX - WIDTH'(1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0]          cnt_q, cnt_d;
  pwm_dir_e                  dir_q, dir_d;
  pwm_mode_e                 mode_q;
  logic [PRESCALE_W-1:0]     ps_q;
  logic [CHANNELS*WIDTH-1:0] shadow_q, active_q;
  logic                      pending_q;
  logic                      tick, wrap, commit;
  logic [CHANNELS-1:0]       lvl;

  pwm_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en_i     (en_i),
    .reload_i (ps_q),
    .tick_o   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Center mode turns at MAX-1 -> MAX so the down leg covers MAX..1 and the period is 2*MAX.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    wrap  = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (tick) begin
      unique case (dir_q)
        DIR_UP: begin
          if (cnt_q == MAX_M1) begin
            if (mode_q == MODE_CENTER) begin
              cnt_d = MAX;
              dir_d = DIR_DOWN;
            end else begin
              cnt_d = '0;
              wrap  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
        DIR_DOWN: begin
          if (cnt_q == ONE) begin
            cnt_d = '0;
            dir_d = DIR_UP;
            wrap  = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      endcase
    end
  end

  // While disabled every clock is a commit, so pending settings land immediately.
  assign commit = !en_i || wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      ps_q      <= '0;
      mode_q    <= MODE_EDGE;
      period_o  <= 1'b0;
    end else begin
      if (duty_load_i) begin
        shadow_q  <= duty_i;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
      if (commit) begin
        if (pending_q) begin
          active_q <= shadow_q;
        end
        ps_q   <= prescale_i;
        mode_q <= pwm_mode_e'(mode_i);
      end
      period_o <= wrap;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] duty_k;
    assign duty_k = active_q[k*WIDTH +: WIDTH];
    assign lvl[k] = (dir_q == DIR_DOWN) ? (cnt_q <= duty_k) : (cnt_q < duty_k);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_o <= '0;
    end else if (!en_i) begin
      pwm_o <= inv_i;
    end else begin
      pwm_o <= lvl ^ inv_i;
    end
  end

endmodule
